alu_issue_queue: RTL

- Operand/opcode front-end for the team's combinational ALU (A, B, 4-bit Opcode in; Y and 5-bit status out).
- Buffers requests in a small FIFO, presents one request at a time on registered ALU inputs, then captures Y/status into an output register.
- Results are offered on a valid/ready interface with backpressure, so the ALU can sit between a producer and a consumer that are not cycle-locked.

---
 rtl/alu_issue_queue.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_issue_queue.sv
// Issue queue in front of a combinational ALU: buffers requests, drives registered
// operands one at a time, and returns captured results over a valid/ready port.
module alu_issue_queue #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             in_a,
  input  logic [N-1:0]             in_b,
  input  logic [3:0]               in_opcode,
  output logic [N-1:0]             alu_a,
  output logic [N-1:0]             alu_b,
  output logic [3:0]               alu_opcode,
  input  logic [N-1:0]             alu_y,
  input  logic [4:0]               alu_status,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             out_y,
  output logic [4:0]               out_status,
  output logic [3:0]               out_opcode,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = 4;

  typedef struct packed {
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [OW-1:0] opcode;
  } req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state, state_n;
  req_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push_c, pop_c, capture_c, release_c;
  req_t          head_c;

  assign in_ready = (fifo_count < CW'(DEPTH));
  assign push_c   = in_valid && in_ready;
  assign head_c   = mem[rd_ptr];

  // Sequencing: pops consult the pre-edge count, so a same-edge push is never bypassed.
  always_comb begin
    state_n   = state;
    pop_c     = 1'b0;
    capture_c = 1'b0;
    release_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop_c   = 1'b1;
          state_n = EXEC;
        end
      end
      EXEC: begin
        capture_c = 1'b1;
        state_n   = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          release_c = 1'b1;
          if (fifo_count != '0) begin
            pop_c   = 1'b1;
            state_n = EXEC;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Storage array needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= '{a: in_a, b: in_b, opcode: in_opcode};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push_c, pop_c})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
    end else if (pop_c) begin
      alu_a      <= head_c.a;
      alu_b      <= head_c.b;
      alu_opcode <= head_c.opcode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_y      <= '0;
      out_status <= '0;
      out_opcode <= '0;
    end else if (capture_c) begin
      out_valid  <= 1'b1;
      out_y      <= alu_y;
      out_status <= alu_status;
      out_opcode <= alu_opcode;
    end else if (release_c) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
